// File: rtl/hdlc_rx_frame_buff_if.sv
// Bus between the HDLC Rx deframer/register port and the single-frame Rx buffer.
interface hdlc_rx_frame_buff_if #(
  parameter int DATA_W = 8,
  parameter int SIZE_W = 8
);
  logic              Rx_WrBuff;
  logic [DATA_W-1:0] Rx_Data;
  logic              Rx_EoF;
  logic              Rx_FCSen;
  logic              Rx_FCSerr;
  logic              Rx_AbortDetect;
  logic              Rx_FrameError;
  logic              Rx_Drop;
  logic              Rx_RdBuff;
  logic [DATA_W-1:0] Rx_DataBuffOut;
  logic              Rx_Ready;
  logic [SIZE_W-1:0] Rx_FrameSize;
  logic              Rx_Overflow;
  logic              Rx_FrameLost;

  modport slave (
    input  Rx_WrBuff, Rx_Data, Rx_EoF, Rx_FCSen, Rx_FCSerr,
    input  Rx_AbortDetect, Rx_FrameError, Rx_Drop, Rx_RdBuff,
    output Rx_DataBuffOut, Rx_Ready, Rx_FrameSize, Rx_Overflow, Rx_FrameLost
  );

  modport master (
    output Rx_WrBuff, Rx_Data, Rx_EoF, Rx_FCSen, Rx_FCSerr,
    output Rx_AbortDetect, Rx_FrameError, Rx_Drop, Rx_RdBuff,
    input  Rx_DataBuffOut, Rx_Ready, Rx_FrameSize, Rx_Overflow, Rx_FrameLost
  );
endinterface

// File: rtl/hdlc_rx_frame_buff.sv
// Single-frame HDLC Rx buffer: collects one frame, strips the FCS, drops bad/runt
// frames and hands the accepted payload to the register read port.
module hdlc_rx_frame_buff #(
  parameter int DEPTH     = 128,
  parameter int DATA_W    = 8,
  parameter int FCS_BYTES = 2,
  parameter int SIZE_W    = $clog2(DEPTH + 1)
) (
  input logic                   Clk,
  input logic                   Rst,
  hdlc_rx_frame_buff_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SIZE_W-1:0] DEPTH_C = SIZE_W'(DEPTH);
  localparam logic [SIZE_W-1:0] FCS_C   = SIZE_W'(FCS_BYTES);
  localparam logic [SIZE_W-1:0] ONE_C   = SIZE_W'(1);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_READY} state_e;

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] wcnt_q, wcnt_d;
  logic [SIZE_W-1:0] rptr_q, rptr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              ovf_q, ovf_d;
  logic              overflow_q, overflow_d;
  logic              lost_q, lost_d;
  logic              lost_seen_q, lost_seen_d;
  logic [DATA_W-1:0] dout_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic              rd_en;

  logic              wr, discard, frame_end, has_room, len_ok;
  logic [SIZE_W-1:0] wcnt_eff, fcs_len, len, rptr_inc;

  assign wr        = bus.Rx_WrBuff;
  assign discard   = bus.Rx_AbortDetect | bus.Rx_FrameError | bus.Rx_Drop;
  assign frame_end = bus.Rx_EoF | bus.Rx_AbortDetect | bus.Rx_FrameError;
  assign has_room  = (wcnt_q < DEPTH_C);
  // End-of-frame length accounts for a word written in the same cycle as Rx_EoF.
  assign wcnt_eff  = wcnt_q + ((wr && has_room) ? ONE_C : '0);
  assign fcs_len   = bus.Rx_FCSen ? FCS_C : '0;
  assign len_ok    = !bus.Rx_FCSerr && (wcnt_eff > fcs_len);
  assign len       = wcnt_eff - fcs_len;
  assign rptr_inc  = rptr_q + ONE_C;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rptr_d      = rptr_q;
    size_d      = size_q;
    ovf_d       = ovf_q;
    overflow_d  = overflow_q;
    mem_we      = 1'b0;
    mem_waddr   = wcnt_q[AW-1:0];
    rd_en       = 1'b0;
    lost_d      = (state_q == S_READY) && wr && !lost_seen_q;
    lost_seen_d = frame_end ? 1'b0 :
                  ((state_q == S_READY) && wr) ? 1'b1 : lost_seen_q;

    case (state_q)
      S_EMPTY: begin
        if (wr) begin
          mem_we     = 1'b1;
          mem_waddr  = '0;
          wcnt_d     = ONE_C;
          ovf_d      = 1'b0;
          overflow_d = 1'b0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (discard) begin
          state_d = S_EMPTY;
          wcnt_d  = '0;
        end else begin
          if (wr) begin
            if (has_room) begin
              mem_we = 1'b1;
              wcnt_d = wcnt_q + ONE_C;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (bus.Rx_EoF) begin
            state_d = S_EMPTY;
            wcnt_d  = '0;
            if (len_ok) begin
              state_d    = S_READY;
              size_d     = len;
              overflow_d = ovf_q | (wr && !has_room);
              rptr_d     = '0;
            end
          end
        end
      end
      S_READY: begin
        if (bus.Rx_Drop) begin
          state_d = S_EMPTY;
        end else if (bus.Rx_RdBuff) begin
          rd_en  = 1'b1;
          rptr_d = rptr_inc;
          if (rptr_inc == size_q) state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_EMPTY;
      wcnt_q      <= '0;
      rptr_q      <= '0;
      size_q      <= '0;
      ovf_q       <= 1'b0;
      overflow_q  <= 1'b0;
      lost_q      <= 1'b0;
      lost_seen_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rptr_q      <= rptr_d;
      size_q      <= size_d;
      ovf_q       <= ovf_d;
      overflow_q  <= overflow_d;
      lost_q      <= lost_d;
      lost_seen_q <= lost_seen_d;
      if (rd_en) dout_q <= mem_q[rptr_q[AW-1:0]];
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_waddr] <= bus.Rx_Data;
  end

  assign bus.Rx_DataBuffOut = dout_q;
  assign bus.Rx_Ready       = (state_q == S_READY);
  assign bus.Rx_FrameSize   = size_q;
  assign bus.Rx_Overflow    = overflow_q;
  assign bus.Rx_FrameLost   = lost_q;

endmodule

// File: tb/tb_hdlc_rx_frame_buff.sv
// Self-checking bench: queue-based frame model checked every cycle on a 128/CRC-16
// instance, plus literal checks and a 16-word/CRC-32 instance for reset and size cases.
module tb_hdlc_rx_frame_buff;

  localparam int D1 = 128;
  localparam int F1 = 2;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst2_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hdlc_rx_frame_buff_if #(.DATA_W(8), .SIZE_W(8)) bus1();
  hdlc_rx_frame_buff_if #(.DATA_W(8), .SIZE_W(5)) bus2();

  hdlc_rx_frame_buff #(.DEPTH(D1), .DATA_W(8), .FCS_BYTES(F1)) dut1 (
    .Clk(clk), .Rst(rst1_n), .bus(bus1)
  );
  hdlc_rx_frame_buff #(.DEPTH(16), .DATA_W(8), .FCS_BYTES(4)) dut2 (
    .Clk(clk), .Rst(rst2_n), .bus(bus2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the frame being collected and the accepted frame as queues.
  logic [7:0] m_cur[$];
  logic [7:0] m_st[$];
  bit         m_filling, m_cur_ovf, m_ovf, m_lost, m_lost_seen;
  logic [7:0] m_size, m_dout;

  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      m_cur.delete(); m_st.delete();
      m_filling = 0; m_cur_ovf = 0; m_ovf = 0; m_lost = 0; m_lost_seen = 0;
      m_size = 0; m_dout = 0;
    end else begin
      m_lost = 0;
      if (m_st.size() != 0) begin
        if (bus1.Rx_Drop) m_st.delete();
        else if (bus1.Rx_RdBuff) m_dout = m_st.pop_front();
        if (bus1.Rx_WrBuff) begin
          if (!m_lost_seen) m_lost = 1;
          m_lost_seen = 1;
        end
      end else if (m_filling) begin
        if (bus1.Rx_AbortDetect || bus1.Rx_FrameError || bus1.Rx_Drop) begin
          m_filling = 0; m_cur.delete();
        end else begin
          if (bus1.Rx_WrBuff) begin
            if (m_cur.size() < D1) m_cur.push_back(bus1.Rx_Data);
            else m_cur_ovf = 1;
          end
          if (bus1.Rx_EoF) begin
            int len;
            len = int'(m_cur.size()) - (bus1.Rx_FCSen ? F1 : 0);
            if (!bus1.Rx_FCSerr && len > 0) begin
              for (int k = 0; k < len; k++) m_st.push_back(m_cur[k]);
              m_size = 8'(len);
              m_ovf = m_cur_ovf;
            end
            m_filling = 0; m_cur.delete();
          end
        end
      end else if (bus1.Rx_WrBuff) begin
        m_filling = 1; m_cur.delete(); m_cur.push_back(bus1.Rx_Data);
        m_cur_ovf = 0; m_ovf = 0;
      end
      if (bus1.Rx_EoF || bus1.Rx_AbortDetect || bus1.Rx_FrameError) m_lost_seen = 0;
    end
  end

  always @(negedge clk) begin
    check("ready",    bus1.Rx_Ready,       32'(m_st.size() != 0));
    check("size",     bus1.Rx_FrameSize,   m_size);
    check("overflow", bus1.Rx_Overflow,    m_ovf);
    check("lost",     bus1.Rx_FrameLost,   m_lost);
    check("dout",     bus1.Rx_DataBuffOut, m_dout);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr1();
    bus1.Rx_WrBuff = 0; bus1.Rx_Data = 0; bus1.Rx_EoF = 0; bus1.Rx_FCSen = 0;
    bus1.Rx_FCSerr = 0; bus1.Rx_AbortDetect = 0; bus1.Rx_FrameError = 0;
    bus1.Rx_Drop = 0; bus1.Rx_RdBuff = 0;
  endtask

  task automatic clr2();
    bus2.Rx_WrBuff = 0; bus2.Rx_Data = 0; bus2.Rx_EoF = 0; bus2.Rx_FCSen = 0;
    bus2.Rx_FCSerr = 0; bus2.Rx_AbortDetect = 0; bus2.Rx_FrameError = 0;
    bus2.Rx_Drop = 0; bus2.Rx_RdBuff = 0;
  endtask

  task automatic wr1(input logic [7:0] d);
    bus1.Rx_WrBuff = 1; bus1.Rx_Data = d; tick(); clr1();
  endtask

  task automatic eof1(input bit fcsen, input bit err);
    bus1.Rx_EoF = 1; bus1.Rx_FCSen = fcsen; bus1.Rx_FCSerr = err; tick(); clr1();
  endtask

  task automatic rd1();
    bus1.Rx_RdBuff = 1; tick(); clr1();
  endtask

  initial begin
    clr1(); clr2();
    repeat (3) tick();
    check("rst ready",  bus1.Rx_Ready, 0);
    check("rst size",   bus1.Rx_FrameSize, 0);
    check("rst dout",   bus1.Rx_DataBuffOut, 0);
    check("rst2 ready", bus2.Rx_Ready, 0);
    rst1_n = 1; rst2_n = 1;
    tick();

    // Basic frame with CRC-16 stripped
    for (int i = 1; i <= 10; i++) wr1(8'(i));
    check("t1 ready before eof", bus1.Rx_Ready, 0);
    eof1(1, 0);
    check("t1 ready", bus1.Rx_Ready, 1);
    check("t1 size",  bus1.Rx_FrameSize, 8);
    for (int i = 1; i <= 8; i++) begin
      rd1();
      check("t1 data", bus1.Rx_DataBuffOut, 32'(i));
    end
    check("t1 ready after last", bus1.Rx_Ready, 0);

    // Overflow, no FCS stripping
    for (int i = 0; i < 130; i++) wr1(8'(i) ^ 8'h5A);
    eof1(0, 0);
    check("t2 overflow", bus1.Rx_Overflow, 1);
    check("t2 size",     bus1.Rx_FrameSize, 128);
    for (int i = 0; i < 128; i++) begin
      rd1();
      check("t2 data", bus1.Rx_DataBuffOut, 32'(8'(i) ^ 8'h5A));
    end
    check("t2 ready after last", bus1.Rx_Ready, 0);

    // Abort, then a clean 4-word frame
    for (int i = 0; i < 5; i++) wr1(8'h10 + 8'(i));
    bus1.Rx_AbortDetect = 1; tick(); clr1();
    for (int i = 0; i < 4; i++) wr1(8'hA0 + 8'(i));
    eof1(0, 0);
    check("t3 ready",    bus1.Rx_Ready, 1);
    check("t3 size",     bus1.Rx_FrameSize, 4);
    check("t3 overflow", bus1.Rx_Overflow, 0);
    for (int i = 0; i < 4; i++) begin
      rd1();
      check("t3 data", bus1.Rx_DataBuffOut, 32'hA0 + 32'(i));
    end

    // FCS error and runt frame are both refused
    for (int i = 0; i < 6; i++) wr1(8'h30 + 8'(i));
    eof1(1, 1);
    check("t4 fcserr ready", bus1.Rx_Ready, 0);
    wr1(8'h77); wr1(8'h78);
    eof1(1, 0);
    check("t4 runt ready", bus1.Rx_Ready, 0);
    check("t4 size held",  bus1.Rx_FrameSize, 4);

    // Incoming frame while READY is lost exactly once
    for (int i = 0; i < 3; i++) wr1(8'hC0 + 8'(i));
    eof1(0, 0);
    check("t5 ready", bus1.Rx_Ready, 1);
    wr1(8'hE0);
    check("t5 lost pulse", bus1.Rx_FrameLost, 1);
    wr1(8'hE1);
    check("t5 lost once", bus1.Rx_FrameLost, 0);
    wr1(8'hE2);
    eof1(0, 0);
    check("t5 lost quiet", bus1.Rx_FrameLost, 0);
    rd1();
    check("t5 data kept", bus1.Rx_DataBuffOut, 32'hC0);
    bus1.Rx_Drop = 1; tick(); clr1();
    check("t5 drop ready", bus1.Rx_Ready, 0);
    check("t5 drop size",  bus1.Rx_FrameSize, 3);
    rd1();
    check("t5 dout hold",  bus1.Rx_DataBuffOut, 32'hC0);

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bus1.Rx_WrBuff      = ($urandom_range(0, 99) < 55);
      bus1.Rx_Data        = 8'($urandom);
      bus1.Rx_EoF         = ($urandom_range(0, 99) < 8);
      bus1.Rx_FCSen       = 1'($urandom);
      bus1.Rx_FCSerr      = ($urandom_range(0, 99) < 15);
      bus1.Rx_AbortDetect = ($urandom_range(0, 99) < 2);
      bus1.Rx_FrameError  = ($urandom_range(0, 99) < 2);
      bus1.Rx_Drop        = ($urandom_range(0, 99) < 2);
      bus1.Rx_RdBuff      = ($urandom_range(0, 99) < 45);
      tick();
    end
    clr1();
    tick();

    // 16-word / CRC-32 instance: overflowed frame, then async reset mid-fill
    for (int i = 0; i < 18; i++) begin
      bus2.Rx_WrBuff = 1; bus2.Rx_Data = 8'h40 + 8'(i); tick();
    end
    clr2();
    bus2.Rx_EoF = 1; bus2.Rx_FCSen = 1; tick(); clr2();
    check("d16 ready",    bus2.Rx_Ready, 1);
    check("d16 size",     bus2.Rx_FrameSize, 12);
    check("d16 overflow", bus2.Rx_Overflow, 1);
    for (int i = 0; i < 12; i++) begin
      bus2.Rx_RdBuff = 1; tick(); clr2();
      check("d16 data", bus2.Rx_DataBuffOut, 32'h40 + 32'(i));
    end
    check("d16 ready after last", bus2.Rx_Ready, 0);
    for (int i = 0; i < 3; i++) begin
      bus2.Rx_WrBuff = 1; bus2.Rx_Data = 8'h90 + 8'(i); tick();
    end
    clr2();
    #2 rst2_n = 0;
    #1;
    check("arst ready",    bus2.Rx_Ready, 0);
    check("arst size",     bus2.Rx_FrameSize, 0);
    check("arst overflow", bus2.Rx_Overflow, 0);
    check("arst lost",     bus2.Rx_FrameLost, 0);
    check("arst dout",     bus2.Rx_DataBuffOut, 0);
    tick();
    rst2_n = 1;
    bus2.Rx_EoF = 1; tick(); clr2();
    check("arst no partial frame", bus2.Rx_Ready, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
